// File: rtl/scan_ctrl_pkg.sv
// Shared types for the serial "101" scan controller and its detector core.
package scan_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    // Detector core states: how much of "101" has been seen so far
    typedef enum logic [1:0] {
        S0 = 2'b00,   // no prefix
        S1 = 2'b01,   // "1"
        S2 = 2'b10    // "10"
    } det_state_t;

endpackage

// File: rtl/mealy_101_core.sv
// Mealy "101" detector: 2-bit state register, combinational y from state and x.
module mealy_101_core
    import scan_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    input  logic clr,       // synchronous return to S0
    input  logic x,
    input  logic overlap,   // 1: the final '1' of a match may start the next one
    output logic y
);

    det_state_t r_state;

    // Advance the prefix tracker one bit per clock; clr wins over x
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
        end else if (clr) begin
            r_state <= S0;
        end else begin
            case (r_state)
                S0:      r_state <= x ? S1 : S0;
                S1:      r_state <= x ? S1 : S2;
                S2:      r_state <= x ? (overlap ? S1 : S0) : S0;
                default: r_state <= S0;
            endcase
        end
    end

    assign y = (r_state == S2) && x;

endmodule

// File: rtl/serial_scan_101_ctrl.sv
// Word-level wrapper: latches a word, feeds it LSB-first into the "101"
// detector core and collects detection count and first-match bit index.
module serial_scan_101_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             overlap,
    output logic             busy,
    output logic             done,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] first_pos,
    output logic             first_valid
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    ctrl_state_t      r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_overlap;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_first_pos;
    logic             r_first_valid;
    logic             r_busy;
    logic             r_done;

    logic w_core_clr;
    logic w_core_x;
    logic w_core_y;
    logic w_match;

    assign w_core_clr = (r_state == LOAD);
    assign w_core_x   = r_shreg[0];
    assign w_match    = (r_state == SHIFT) && w_core_y;

    mealy_101_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_core_clr),
        .x       (w_core_x),
        .overlap (r_overlap),
        .y       (w_core_y)
    );

    // Scan sequencer with shift register, bit counter and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_overlap     <= 1'b0;
            r_bit_cnt     <= '0;
            r_match_cnt   <= '0;
            r_first_pos   <= '0;
            r_first_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state       <= LOAD;
                        r_shreg       <= data_in;
                        r_overlap     <= overlap;
                        r_match_cnt   <= '0;
                        r_first_pos   <= '0;
                        r_first_valid <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                LOAD: begin
                    // core is cleared this cycle via w_core_clr
                    r_state   <= SHIFT;
                    r_bit_cnt <= '0;
                end
                SHIFT: begin
                    r_shreg   <= r_shreg >> 1;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_match) begin
                        r_match_cnt <= r_match_cnt + CNT_W'(1);
                        if (!r_first_valid) begin
                            r_first_pos   <= r_bit_cnt;
                            r_first_valid <= 1'b1;
                        end
                    end
                    if (r_bit_cnt == LAST_BIT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign match_pulse = w_match;
    assign match_cnt   = r_match_cnt;
    assign first_pos   = r_first_pos;
    assign first_valid = r_first_valid;

endmodule

// File: doc/serial_scan_101_ctrl.md
# serial_scan_101_ctrl

Sequencing controller for the Mealy "101" sequence detector. It accepts a parallel word on a start strobe and feeds it LSB-first, one bit per clock, into an embedded detector core. It counts detections in overlapping or non-overlapping mode and records the bit index of the first detection. It then reports completion with a one-cycle done pulse. The block replaces hand-driven serial stimulus wherever a word-level consumer needs pattern statistics.

## Interface
Parameters:
- WIDTH, 20, number of bits per scanned word (≥3)
- CNT_W, $clog2(WIDTH+1), width of count and index outputs

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start  in  1  request scan; accepted only in IDLE
- data_in  in  WIDTH  word to scan; latched on accepted start
- overlap  in  1  1=overlapping detection, 0=non-overlapping; latched on accepted start
- busy  out  1  high in LOAD and SHIFT
- done  out  1  one-cycle pulse in DONE
- match_pulse  out  1  detector y gated by SHIFT (combinational Mealy output)
- match_cnt  out  CNT_W  detections in last/current scan
- first_pos  out  CNT_W  bit index of first detection (index of the final '1')
- first_valid  out  1  at least one detection in last/current scan

## Operation
- Controller states:
  - IDLE: start=1 → LOAD. Latch data_in into shift register and latch overlap. Clear match_cnt, first_pos and first_valid.
  - LOAD: assert a synchronous clear to the core, forcing it to S0 → SHIFT. Load bit counter with 0.
  - SHIFT: core x = shreg[0]. Each edge shifts right and increments the bit counter. When bit counter = WIDTH-1 → DONE.
  - DONE: done=1 → IDLE.
- Core states:
  - S0 (no prefix): x=1→S1, else S0.
  - S1 ("1"): x=0→S2, else S1.
  - S2 ("10"): x=1→y=1. Next state is S1 if overlap, S0 if not. x=0→S0.
  - y=1 only in S2 with x=1.
- On each SHIFT edge where y=1:
  - match_cnt increments.
  - If first_valid=0, first_pos gets the bit counter and first_valid is set.
- Overflow is impossible: match_cnt ≤ WIDTH/2.
- start is ignored in LOAD, SHIFT and DONE; there is no queueing.
- data_in and overlap changes after acceptance have no effect.
- Results hold from DONE until the next accepted start.
- Reset (rst=0) at any time, including mid-SHIFT, is asynchronous:
  - Controller goes to IDLE and the core goes to S0.
  - busy, done, match_cnt, first_pos and first_valid are all 0.
  - The shift register content is don't-care.

## Timing
- start sampled high at edge E0 → LOAD in the cycle after E0.
- Bit k is presented in the cycle after edge E(1+k), k=0..WIDTH-1.
- done is high in the cycle after E(WIDTH+1).
- The block is back in IDLE after E(WIDTH+2).
- Total: WIDTH+2 cycles from accepted start to done; the next start can be accepted in the cycle after done.
- busy rises in the cycle after E0 and falls in the same cycle that done rises.
- match_pulse is valid combinationally within a SHIFT cycle.
- match_cnt, first_pos and first_valid update one edge after a detection.
- A detection on the final bit is already reflected when done=1.

## Structure
- Shared package scan_ctrl_pkg holds:
  - ctrl state enum: IDLE, LOAD, SHIFT, DONE.
  - detector state encoding: S0=2'b00, S1=2'b01, S2=2'b10.
- Sub-module mealy_101_core has ports clk, rst, clr, x, overlap and y.
  - It holds the 2-bit state register.
  - Its y is combinational from state and x.
- The controller contains the shift register, bit counter, result registers and FSM.

## Test plan
- WIDTH=20, data_in=20'b10100010100101010100, overlap=1 → detections at bits 4,6,8,13,19. Required: match_cnt=5, first_pos=4, first_valid=1, done exactly 22 cycles after start edge.
- Same data, overlap=0 → detections at 4,8,13,19. Required: match_cnt=4, first_pos=4.
- data_in=20'h55555:
  - overlap=1 → match_cnt=9, first_pos=2.
  - overlap=0 → match_cnt=5, with match_pulse at bits 2,6,10,14,18.
- data_in=0, then data_in=20'hFFFFF → match_cnt=0 and first_valid=0 both times. Then a start pulse held 3 cycles during a scan → only one scan runs (single done).
- Assert rst=0 mid-SHIFT (bit 7 of the first vector) → busy, done, match_cnt, first_pos and first_valid all 0 immediately. A fresh start after rst=1 reproduces scenario 1 exactly.
- Back-to-back: start in the cycle after done → accepted. Results of the first scan hold through DONE, then clear at acceptance.
